// File: rtl/race_pkg.sv
// Shared FSM encoding and sizing helpers for the race tracker.
package race_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_TURN   = 2'd1,
    ST_RESULT = 2'd2,
    ST_WON    = 2'd3
  } state_t;

  localparam int STEP_W = 8;

  function automatic int pid_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/player_slot.sv
// One player's track position and successful-advance counter.
// Updates one cycle after init/advance; init wins over advance.
module player_slot
  import race_pkg::*;
#(
  parameter int POS_W     = 5,
  parameter int BOARD_LEN = 24,
  parameter int WIN_STEPS = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              advance,
  input  logic [POS_W-1:0]  init_pos,
  output logic [POS_W-1:0]  pos,
  output logic [POS_W-1:0]  next_pos,
  output logic [STEP_W-1:0] steps
);

  logic [POS_W-1:0]  r_pos;
  logic [STEP_W-1:0] r_steps;

  assign next_pos = (r_pos == POS_W'(BOARD_LEN - 1)) ? '0 : r_pos + POS_W'(1);
  assign pos      = r_pos;
  assign steps    = r_steps;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pos   <= '0;
      r_steps <= '0;
    end else if (init) begin
      r_pos   <= init_pos;
      r_steps <= '0;
    end else if (advance) begin
      r_pos <= next_pos;
      // Saturate so the counter can never pass the winning count.
      if (r_steps != STEP_W'(WIN_STEPS))
        r_steps <= r_steps + STEP_W'(1);
    end
  end

endmodule

// File: rtl/race_tracker.sv
// Turn-based race: players guess the tile ahead; a hit advances, a miss passes the turn.
// Result pulses one cycle after the accepted guess; guess_ready is high only while waiting for a guess.
module race_tracker
  import race_pkg::*;
#(
  parameter  int NUM_PLAYERS = 4,
  parameter  int POS_W       = 5,
  parameter  int BOARD_LEN   = 24,
  parameter  int WIN_STEPS   = 24,
  localparam int PID_W       = pid_width(NUM_PLAYERS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         new_game,
  input  logic                         guess_valid,
  input  logic [POS_W-1:0]             guess_tile,
  input  logic [POS_W-1:0]             target_tile,
  output logic                         guess_ready,
  output logic [PID_W-1:0]             turn,
  output logic [POS_W-1:0]             cur_next_pos,
  output logic                         hit,
  output logic                         miss,
  output logic                         win,
  output logic [PID_W-1:0]             winner,
  output logic [NUM_PLAYERS*POS_W-1:0] positions
);

  localparam int NSLOT = 2 ** PID_W;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PID_W-1:0]  r_turn;
  logic              r_match;
  logic              w_xfer;
  logic              w_match;
  logic [POS_W-1:0]  w_next  [NSLOT];
  logic [STEP_W-1:0] w_steps [NSLOT];

  // A simultaneous new_game discards the guess entirely.
  assign w_xfer  = (r_state == ST_TURN) && guess_valid && !new_game;
  assign w_match = (guess_tile == target_tile);

  for (genvar p = 0; p < NSLOT; p++) begin : g_slot
    if (p < NUM_PLAYERS) begin : g_used
      player_slot #(
        .POS_W     (POS_W),
        .BOARD_LEN (BOARD_LEN),
        .WIN_STEPS (WIN_STEPS)
      ) u_slot (
        .clk      (clk),
        .rst      (rst),
        .init     (new_game),
        .advance  (w_xfer && w_match && (r_turn == PID_W'(p))),
        .init_pos (POS_W'(p * (BOARD_LEN / NUM_PLAYERS))),
        .pos      (positions[p*POS_W +: POS_W]),
        .next_pos (w_next[p]),
        .steps    (w_steps[p])
      );
    end else begin : g_pad
      assign w_next[p]  = '0;
      assign w_steps[p] = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_turn  <= '0;
      r_match <= 1'b0;
    end else if (new_game) begin
      r_turn  <= '0;
      r_match <= 1'b0;
    end else if (w_xfer) begin
      r_match <= w_match;
      if (!w_match)
        r_turn <= (r_turn == PID_W'(NUM_PLAYERS - 1)) ? '0 : r_turn + PID_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (new_game) begin
      w_state_nxt = ST_TURN;
    end else begin
      case (r_state)
        ST_TURN:   if (guess_valid) w_state_nxt = ST_RESULT;
        // Turn is unchanged on a hit, so r_turn still names the player who just advanced.
        ST_RESULT: w_state_nxt = (w_steps[r_turn] == STEP_W'(WIN_STEPS)) ? ST_WON : ST_TURN;
        default:   w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    guess_ready = 1'b0;
    hit         = 1'b0;
    miss        = 1'b0;
    win         = 1'b0;
    winner      = '0;
    case (r_state)
      ST_TURN:   guess_ready = 1'b1;
      ST_RESULT: begin
        hit  = r_match;
        miss = !r_match;
      end
      ST_WON: begin
        win    = 1'b1;
        winner = r_turn;
      end
      default: ;
    endcase
  end

  assign turn         = r_turn;
  assign cur_next_pos = w_next[r_turn];

endmodule

// File: tb/tb_race_tracker.sv
// Randomized plus directed check of two race_tracker configurations against a behavioural game model.
module tb_race_tracker;
  localparam int BL = 24;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       ng [2];
  logic       gv [2];
  logic [4:0] gt [2];
  logic [4:0] tt [2];

  wire        a_rdy, a_hit, a_miss, a_win;
  wire [1:0]  a_turn, a_winner;
  wire [4:0]  a_cnp;
  wire [19:0] a_pos;
  wire        b_rdy, b_hit, b_miss, b_win;
  wire [1:0]  b_turn, b_winner;
  wire [4:0]  b_cnp;
  wire [14:0] b_pos;

  race_tracker u_a (
    .clk(clk), .rst(rst), .new_game(ng[0]), .guess_valid(gv[0]),
    .guess_tile(gt[0]), .target_tile(tt[0]), .guess_ready(a_rdy), .turn(a_turn),
    .cur_next_pos(a_cnp), .hit(a_hit), .miss(a_miss), .win(a_win),
    .winner(a_winner), .positions(a_pos)
  );

  race_tracker #(.NUM_PLAYERS(3), .WIN_STEPS(2)) u_b (
    .clk(clk), .rst(rst), .new_game(ng[1]), .guess_valid(gv[1]),
    .guess_tile(gt[1]), .target_tile(tt[1]), .guess_ready(b_rdy), .turn(b_turn),
    .cur_next_pos(b_cnp), .hit(b_hit), .miss(b_miss), .win(b_win),
    .winner(b_winner), .positions(b_pos)
  );

  // Game model: phase 0 idle, 1 awaiting guess, 2 showing result, 3 won.
  int np [2] = '{4, 3};
  int ws [2] = '{24, 2};
  int m_phase [2];
  int m_turn  [2];
  int m_match [2];
  int m_pos   [2][8];
  int m_steps [2][8];
  int n_cmp = 0;
  int n_bad = 0;

  task automatic m_reset();
    for (int d = 0; d < 2; d++) begin
      m_phase[d] = 0; m_turn[d] = 0; m_match[d] = 0;
      for (int p = 0; p < 8; p++) begin
        m_pos[d][p] = 0; m_steps[d][p] = 0;
      end
    end
  endtask

  task automatic m_step();
    for (int d = 0; d < 2; d++) begin
      if (ng[d]) begin
        m_phase[d] = 1; m_turn[d] = 0;
        for (int p = 0; p < 8; p++) begin
          m_pos[d][p]   = (p < np[d]) ? p * (BL / np[d]) : 0;
          m_steps[d][p] = 0;
        end
      end else if (m_phase[d] == 1) begin
        if (gv[d]) begin
          m_match[d] = (gt[d] == tt[d]) ? 1 : 0;
          if (m_match[d] == 1) begin
            m_pos[d][m_turn[d]]   = (m_pos[d][m_turn[d]] + 1) % BL;
            m_steps[d][m_turn[d]] = m_steps[d][m_turn[d]] + 1;
          end else begin
            m_turn[d] = (m_turn[d] + 1) % np[d];
          end
          m_phase[d] = 2;
        end
      end else if (m_phase[d] == 2) begin
        m_phase[d] = (m_steps[d][m_turn[d]] == ws[d]) ? 3 : 1;
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) m_reset();
    else      m_step();
  end

  task automatic chk(input string nm, input int d, input logic [39:0] act, input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s dut%0d: got %0h want %0h at %0t", nm, d, act, exp, $time);
    end
  endtask

  task automatic cmp_dut(input int d, input logic rdy, input logic hit, input logic miss,
                         input logic win, input logic [1:0] trn, input logic [1:0] wnr,
                         input logic [4:0] cnp, input logic [39:0] pos);
    logic [39:0] ep;
    ep = '0;
    for (int p = 0; p < np[d]; p++) ep = ep | (40'(m_pos[d][p]) << (5 * p));
    chk("ready",  d, 40'(rdy),  40'(m_phase[d] == 1));
    chk("hit",    d, 40'(hit),  40'(m_phase[d] == 2 && m_match[d] == 1));
    chk("miss",   d, 40'(miss), 40'(m_phase[d] == 2 && m_match[d] == 0));
    chk("win",    d, 40'(win),  40'(m_phase[d] == 3));
    chk("winner", d, 40'(wnr),  40'((m_phase[d] == 3) ? m_turn[d] : 0));
    chk("turn",   d, 40'(trn),  40'(m_turn[d]));
    chk("cnp",    d, 40'(cnp),  40'((m_pos[d][m_turn[d]] + 1) % BL));
    chk("pos",    d, pos,       ep);
  endtask

  initial forever begin
    @(negedge clk);
    cmp_dut(0, a_rdy, a_hit, a_miss, a_win, a_turn, a_winner, a_cnp, 40'(a_pos));
    cmp_dut(1, b_rdy, b_hit, b_miss, b_win, b_turn, b_winner, b_cnp, 40'(b_pos));
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic play(input int d, input int g, input int t);
    gv[d] = 1'b1; gt[d] = 5'(g); tt[d] = 5'(t);
    tick();
    gv[d] = 1'b0;
  endtask

  logic [19:0] e4;
  logic [14:0] e3;

  initial begin
    for (int d = 0; d < 2; d++) begin
      ng[d] = 1'b0; gv[d] = 1'b0; gt[d] = '0; tt[d] = '0;
    end
    m_reset();
    #1 rst = 1'b0;
    tick();
    chk("rst_ready", 0, 40'(a_rdy), 40'(0));
    chk("rst_pos",   0, 40'(a_pos), 40'(0));
    rst = 1'b1;
    tick();
    chk("idle_hold", 0, 40'(a_rdy), 40'(0));

    // Default configuration: initial layout, hit, miss, wrap.
    e4 = {5'd18, 5'd12, 5'd6, 5'd0};
    ng[0] = 1'b1; tick(); ng[0] = 1'b0;
    chk("init_pos4",   0, 40'(a_pos), 40'(e4));
    chk("init_ready",  0, 40'(a_rdy), 40'(1));
    play(0, 7, 7);
    chk("first_hit",   0, 40'(a_hit), 40'(1));
    chk("pos0_adv",    0, 40'(a_pos[4:0]), 40'(1));
    chk("turn_kept",   0, 40'(a_turn), 40'(0));
    tick();
    chk("hit_pulse",   0, 40'(a_hit), 40'(0));
    play(0, 3, 5);
    chk("first_miss",  0, 40'(a_miss), 40'(1));
    chk("turn_next",   0, 40'(a_turn), 40'(1));
    tick();
    play(0, 1, 2); tick();
    play(0, 1, 2); tick();
    chk("turn_p3",     0, 40'(a_turn), 40'(3));
    for (int i = 0; i < 5; i++) begin
      play(0, 4, 4); tick();
    end
    chk("pos3_23",     0, 40'(a_pos[19:15]), 40'(23));
    play(0, 9, 9);
    chk("pos3_wrap",   0, 40'(a_pos[19:15]), 40'(0));
    tick();
    play(0, 9, 8);
    chk("turn_wrap4",  0, 40'(a_turn), 40'(0));
    tick();

    // new_game beats a simultaneous guess.
    ng[0] = 1'b1; gv[0] = 1'b1; gt[0] = 5'd2; tt[0] = 5'd2;
    tick();
    ng[0] = 1'b0; gv[0] = 1'b0;
    chk("abort_hit",   0, 40'(a_hit | a_miss), 40'(0));
    chk("abort_pos",   0, 40'(a_pos), 40'(e4));

    // Asynchronous reset in the middle of a result cycle.
    play(0, 6, 6);
    chk("pre_rst_hit", 0, 40'(a_hit), 40'(1));
    rst = 1'b0;
    #1;
    chk("rst_async",   0, 40'(a_hit), 40'(0));
    tick();
    chk("rst_pos_mid", 0, 40'(a_pos), 40'(0));
    rst = 1'b1;
    tick();
    chk("rst_idle",    0, 40'(a_rdy), 40'(0));

    // Three players, two steps to win.
    e3 = {5'd16, 5'd8, 5'd0};
    ng[1] = 1'b1; tick(); ng[1] = 1'b0;
    chk("init_pos3",   1, 40'(b_pos), 40'(e3));
    play(1, 1, 0); tick();
    play(1, 1, 0); tick();
    chk("turn_p2",     1, 40'(b_turn), 40'(2));
    play(1, 1, 0);
    chk("turn_wrap3",  1, 40'(b_turn), 40'(0));
    tick();
    play(1, 3, 3); tick();
    play(1, 3, 3);
    chk("win_hit",     1, 40'(b_hit), 40'(1));
    tick();
    chk("win_lvl",     1, 40'(b_win), 40'(1));
    chk("winner0",     1, 40'(b_winner), 40'(0));
    chk("won_ready",   1, 40'(b_rdy), 40'(0));
    gv[1] = 1'b1; gt[1] = 5'd4; tt[1] = 5'd4;
    repeat (3) tick();
    gv[1] = 1'b0;
    chk("won_hold",    1, 40'(b_win), 40'(1));
    chk("won_frozen",  1, 40'(b_pos), 40'({5'd16, 5'd8, 5'd2}));

    // Random play on both configurations.
    for (int i = 0; i < 4000; i++) begin
      tick();
      if ($urandom_range(699) == 0) begin
        rst = 1'b0; #2; rst = 1'b1;
      end
      for (int d = 0; d < 2; d++) begin
        if (m_phase[d] == 0 || m_phase[d] == 3) ng[d] = ($urandom_range(5) == 0);
        else                                     ng[d] = ($urandom_range(99) == 0);
        gv[d] = ($urandom_range(2) != 0);
        tt[d] = 5'($urandom);
        gt[d] = ($urandom_range(1) == 0) ? tt[d] : 5'($urandom);
      end
    end
    for (int d = 0; d < 2; d++) begin
      ng[d] = 1'b0; gv[d] = 1'b0;
    end
    tick();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
